stack_memory_controller: RTL and testbench
==========================================

Name: stack_memory_controller

Overview:
- Sits in the execute-memory stage directly upstream of the data memory. It decodes the stage's memory operation and owns the stack pointer (SP).
- It drives the data memory's address, write-data, read and write controls, including the two-cycle sequencing of CALL/RET 32-bit PC transfers, and stalls upstream while it does so.
- It captures data returned by the data memory and presents load/pop results and the return PC to the writeback side.

Parameters:
- ADDR_W, 12: SP width; memory depth is 2**ADDR_W words.
- STACK_TOP, 12'hFFF: SP reset value, the highest word address; the stack grows down.
- STACK_LIMIT, 12'h800: lowest address a push may write.

Ports:
- i_clk  in  1  system clock; all state updates on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  operation valid this cycle.
- i_op  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET, 7 treated as NOP.
- i_address  in  16  effective address for LOAD/STORE.
- i_write_data  in  16  data for STORE/PUSH.
- i_pc  in  32  return PC pushed by CALL.
- i_mem_read_data  in  16  data memory read output (updated at negedge).
- o_mem_address  out  16  data memory address.
- o_mem_write_data  out  16  data memory write data.
- o_mem_read  out  1  data memory read enable.
- o_mem_write  out  1  data memory write enable.
- o_stall  out  1  hold upstream inputs stable.
- o_done  out  1  one-cycle pulse: operation completed.
- o_read_data  out  16  LOAD/POP result.
- o_ret_pc  out  32  PC popped by RET.
- o_sp  out  16  current SP, zero-extended.
- o_stack_fault  out  1  one-cycle pulse: overflow or underflow.

Behaviour:

Memory interface timing:
- o_mem_* are combinational from state and inputs in the access cycle; the data memory acts at the mid-cycle negedge.
- i_mem_read_data is sampled at the following posedge.

State machine (states IDLE, SECOND):
- IDLE:
  - LOAD: addr = i_address, read.
  - STORE: addr = i_address, write i_write_data.
  - PUSH: addr = SP, write i_write_data; SP <= SP-1.
  - POP: addr = SP+1, read; SP <= SP+1.
  - CALL: addr = SP, write i_pc[31:16]; o_stall = 1; go to SECOND.
  - RET: addr = SP+1, read; latch the word into o_ret_pc[15:0]; o_stall = 1; go to SECOND.
- SECOND:
  - CALL: addr = SP-1, write i_pc[15:0]; SP <= SP-2.
  - RET: addr = SP+2, read into o_ret_pc[31:16]; SP <= SP+2.
  - o_stall = 0; return to IDLE.
- The operation is latched at IDLE exit, so SECOND ignores i_op and i_valid.

Results and completion:
- o_read_data and o_ret_pc are registered. They are valid in the cycle after the final access cycle, together with o_done = 1.
- Each holds its value until the next LOAD/POP or RET respectively overwrites it.
- o_done pulses for every completed non-NOP operation, including STORE/PUSH/CALL.
- NOP, or i_valid = 0 in IDLE: no access and no SP change.

Address and arithmetic rules:
- SP arithmetic is ADDR_W-bit.
- o_mem_address is SP-derived, zero-extended to 16 bits.
- LOAD/STORE addresses pass through unmodified.

Stack faults (checked in IDLE, registered pulse next cycle):
- PUSH with SP < STACK_LIMIT.
- CALL with SP < STACK_LIMIT+1.
- POP with SP > STACK_TOP-1.
- RET with SP > STACK_TOP-2.
- On a fault: no memory enable, SP unchanged, no stall, o_done = 0, o_stack_fault = 1.

Reset:
- Outputs: state IDLE, SP = STACK_TOP, o_read_data = 0, o_ret_pc = 0, o_done = 0, o_stack_fault = 0, o_stall = 0.
- While i_reset is high, o_mem_read and o_mem_write are forced to 0 so no write lands.
- Reset during SECOND abandons the CALL/RET (a half-written stack is acceptable) and does not update SP.

Other rules:
- Read and write are never asserted together.
- No operation is accepted while in SECOND.

Decomposition:
- Shared package memory_pkg:
  - op encoding constants: OP_NOP … OP_RET.
  - ADDR_W, STACK_TOP, STACK_LIMIT defaults.
  - state encoding: ST_IDLE, ST_SECOND.
- One natural sub-module, stack_pointer: holds SP and performs the +1/-1/+2/-2 update and the fault comparisons.
- FSM and muxing stay in the top.

Test Plan:
- Reset, then PUSH 16'hABCD:
  - write at 0x0FFF; SP becomes 0x0FFE; o_done = 1 next cycle.
  - Then POP: read at 0x0FFF returns 16'hABCD; SP = 0x0FFF.
- CALL with i_pc = 32'h1234_5678 at SP = 0x0FFF:
  - o_stall high for exactly one cycle.
  - mem[0x0FFF] = 1234, mem[0x0FFE] = 5678; SP = 0x0FFD.
  - Then RET: o_ret_pc = 32'h1234_5678; SP = 0x0FFF.
- STORE 16'h00A5 to 0x0010, then LOAD 0x0010:
  - o_read_data = 16'h00A5; SP unchanged at 0x0FFF.
- POP immediately after reset:
  - o_stack_fault pulses; no o_mem_read; SP stays 0x0FFF; o_done = 0.
- Underflow/overflow bounds:
  - RET at SP = 0x0FFE faults.
  - PUSH at SP = STACK_LIMIT succeeds.
  - PUSH at SP = STACK_LIMIT-1 faults with no write.
- Assert i_reset during CALL's SECOND cycle:
  - o_mem_write = 0 in that cycle.
  - Next cycle: SP = 0x0FFF, state IDLE, o_stall = 0.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared encodings and default geometry for the stack memory controller
// and its stack pointer unit.
package memory_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;
  localparam logic [2:0] OP_CALL  = 3'd5;
  localparam logic [2:0] OP_RET   = 3'd6;

  localparam int          DEF_ADDR_W      = 12;
  localparam logic [11:0] DEF_STACK_TOP   = 12'hFFF;
  localparam logic [11:0] DEF_STACK_LIMIT = 12'h800;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register with +1/-1/+2/-2 updates and the bound checks
// used to reject pushes/pops that would leave the stack window.
module stack_pointer
  import memory_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] STACK_TOP   = DEF_STACK_TOP,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = DEF_STACK_LIMIT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_inc1,
  input  logic              i_dec1,
  input  logic              i_inc2,
  input  logic              i_dec2,
  output logic [ADDR_W-1:0] o_sp,
  output logic [ADDR_W-1:0] o_sp_p1,
  output logic [ADDR_W-1:0] o_sp_p2,
  output logic [ADDR_W-1:0] o_sp_m1,
  output logic              o_push_fault,
  output logic              o_call_fault,
  output logic              o_pop_fault,
  output logic              o_ret_fault
);

  logic [ADDR_W-1:0] r_sp;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sp <= STACK_TOP;
    end else if (i_inc1) begin
      r_sp <= r_sp + ADDR_W'(1);
    end else if (i_dec1) begin
      r_sp <= r_sp - ADDR_W'(1);
    end else if (i_inc2) begin
      r_sp <= r_sp + ADDR_W'(2);
    end else if (i_dec2) begin
      r_sp <= r_sp - ADDR_W'(2);
    end
  end

  assign o_sp    = r_sp;
  assign o_sp_p1 = r_sp + ADDR_W'(1);
  assign o_sp_p2 = r_sp + ADDR_W'(2);
  assign o_sp_m1 = r_sp - ADDR_W'(1);

  // CALL/RET move two words, so their bounds are one word tighter.
  assign o_push_fault = (r_sp < STACK_LIMIT);
  assign o_call_fault = (r_sp < (STACK_LIMIT + ADDR_W'(1)));
  assign o_pop_fault  = (r_sp > (STACK_TOP - ADDR_W'(1)));
  assign o_ret_fault  = (r_sp > (STACK_TOP - ADDR_W'(2)));

endmodule

// File: rtl/stack_memory_controller.sv
// Execute-memory stage controller: decodes memory ops, owns SP, sequences
// two-word CALL/RET transfers and registers load/pop/return-PC results.
module stack_memory_controller
  import memory_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] STACK_TOP   = DEF_STACK_TOP,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = DEF_STACK_LIMIT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [2:0]  i_op,
  input  logic [15:0] i_address,
  input  logic [15:0] i_write_data,
  input  logic [31:0] i_pc,
  input  logic [15:0] i_mem_read_data,
  output logic [15:0] o_mem_address,
  output logic [15:0] o_mem_write_data,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_stall,
  output logic        o_done,
  output logic [15:0] o_read_data,
  output logic [31:0] o_ret_pc,
  output logic [15:0] o_sp,
  output logic        o_stack_fault
);

  function automatic logic [15:0] zext(input logic [ADDR_W-1:0] v);
    logic [15:0] r;
    r = '0;
    r[ADDR_W-1:0] = v;
    return r;
  endfunction

  logic [0:0]  r_state;
  logic        r_sec_ret;
  logic [15:0] r_pc_lo;
  logic [15:0] r_read_data;
  logic [31:0] r_ret_pc;
  logic        r_done;
  logic        r_fault;

  logic [ADDR_W-1:0] w_sp, w_sp_p1, w_sp_p2, w_sp_m1;
  logic w_push_fault, w_call_fault, w_pop_fault, w_ret_fault;
  logic w_idle, w_act;
  logic w_load, w_store, w_push, w_pop, w_call, w_ret;
  logic w_push_ok, w_pop_ok, w_call_ok, w_ret_ok, w_fault;
  logic w_sec_call, w_sec_ret;
  logic [15:0] w_addr, w_wdata;
  logic        w_rd, w_wr;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_act   = w_idle & i_valid;
  assign w_load  = w_act & (i_op == OP_LOAD);
  assign w_store = w_act & (i_op == OP_STORE);
  assign w_push  = w_act & (i_op == OP_PUSH);
  assign w_pop   = w_act & (i_op == OP_POP);
  assign w_call  = w_act & (i_op == OP_CALL);
  assign w_ret   = w_act & (i_op == OP_RET);

  assign w_push_ok = w_push & ~w_push_fault;
  assign w_pop_ok  = w_pop  & ~w_pop_fault;
  assign w_call_ok = w_call & ~w_call_fault;
  assign w_ret_ok  = w_ret  & ~w_ret_fault;
  assign w_fault   = (w_push & w_push_fault) | (w_pop & w_pop_fault) |
                     (w_call & w_call_fault) | (w_ret & w_ret_fault);

  assign w_sec_call = ~w_idle & ~r_sec_ret;
  assign w_sec_ret  = ~w_idle &  r_sec_ret;

  stack_pointer #(
    .ADDR_W      (ADDR_W),
    .STACK_TOP   (STACK_TOP),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_inc1       (w_pop_ok),
    .i_dec1       (w_push_ok),
    .i_inc2       (w_sec_ret),
    .i_dec2       (w_sec_call),
    .o_sp         (w_sp),
    .o_sp_p1      (w_sp_p1),
    .o_sp_p2      (w_sp_p2),
    .o_sp_m1      (w_sp_m1),
    .o_push_fault (w_push_fault),
    .o_call_fault (w_call_fault),
    .o_pop_fault  (w_pop_fault),
    .o_ret_fault  (w_ret_fault)
  );

  // Access-cycle address/data mux; SP stays put until the last word of CALL/RET.
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    if (w_idle) begin
      if (w_load) begin
        w_addr = i_address;
        w_rd   = 1'b1;
      end else if (w_store) begin
        w_addr  = i_address;
        w_wdata = i_write_data;
        w_wr    = 1'b1;
      end else if (w_push_ok) begin
        w_addr  = zext(w_sp);
        w_wdata = i_write_data;
        w_wr    = 1'b1;
      end else if (w_pop_ok || w_ret_ok) begin
        w_addr = zext(w_sp_p1);
        w_rd   = 1'b1;
      end else if (w_call_ok) begin
        w_addr  = zext(w_sp);
        w_wdata = i_pc[31:16];
        w_wr    = 1'b1;
      end
    end else if (r_sec_ret) begin
      w_addr = zext(w_sp_p2);
      w_rd   = 1'b1;
    end else begin
      w_addr  = zext(w_sp_m1);
      w_wdata = r_pc_lo;
      w_wr    = 1'b1;
    end
  end

  assign o_mem_address    = w_addr;
  assign o_mem_write_data = w_wdata;
  assign o_mem_read       = w_rd & ~i_reset;
  assign o_mem_write      = w_wr & ~i_reset;
  assign o_stall          = (w_call_ok | w_ret_ok) & ~i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_sec_ret   <= 1'b0;
      r_read_data <= '0;
      r_ret_pc    <= '0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= (w_call_ok | w_ret_ok) ? ST_SECOND : ST_IDLE;
      if (w_call_ok | w_ret_ok) begin
        r_sec_ret <= w_ret_ok;
      end
      r_done  <= w_load | w_store | w_push_ok | w_pop_ok | ~w_idle;
      r_fault <= w_fault;
      if (w_load | w_pop_ok) begin
        r_read_data <= i_mem_read_data;
      end
      if (w_ret_ok) begin
        r_ret_pc[15:0] <= i_mem_read_data;
      end
      if (w_sec_ret) begin
        r_ret_pc[31:16] <= i_mem_read_data;
      end
    end
  end

  // Low PC half is held for the second CALL word so SECOND needs no live inputs.
  always_ff @(posedge i_clk) begin
    if (w_call_ok) begin
      r_pc_lo <= i_pc[15:0];
    end
  end

  assign o_done        = r_done;
  assign o_stack_fault = r_fault;
  assign o_read_data   = r_read_data;
  assign o_ret_pc      = r_ret_pc;
  assign o_sp          = zext(w_sp);

endmodule

// File: tb/tb_stack_memory_controller.sv
// Randomised scoreboard bench for stack_memory_controller with a word-level
// stack/memory reference model and a negedge-acting data memory.
module tb_stack_memory_controller;
  import memory_pkg::*;

  localparam int TOP = 4095;
  localparam int LIM = 2048;

  logic        i_clk, i_reset, i_valid;
  logic [2:0]  i_op;
  logic [15:0] i_address, i_write_data, i_mem_read_data;
  logic [31:0] i_pc;
  logic [15:0] o_mem_address, o_mem_write_data, o_read_data, o_sp;
  logic        o_mem_read, o_mem_write, o_stall, o_done, o_stack_fault;
  logic [31:0] o_ret_pc;

  stack_memory_controller dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_valid          (i_valid),
    .i_op             (i_op),
    .i_address        (i_address),
    .i_write_data     (i_write_data),
    .i_pc             (i_pc),
    .i_mem_read_data  (i_mem_read_data),
    .o_mem_address    (o_mem_address),
    .o_mem_write_data (o_mem_write_data),
    .o_mem_read       (o_mem_read),
    .o_mem_write      (o_mem_write),
    .o_stall          (o_stall),
    .o_done           (o_done),
    .o_read_data      (o_read_data),
    .o_ret_pc         (o_ret_pc),
    .o_sp             (o_sp),
    .o_stack_fault    (o_stack_fault)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Data memory acting at the mid-cycle negedge.
  logic [15:0] mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    i_mem_read_data = 16'h0;
  end
  always @(negedge i_clk) begin
    if (o_mem_write) mem[o_mem_address] <= o_mem_write_data;
    if (o_mem_read)  i_mem_read_data <= mem[o_mem_address];
  end

  // Reference model: plain integer SP plus a sparse word memory.
  int          m_sp;
  logic [15:0] m_read;
  logic [31:0] m_ret;
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  typedef struct {
    bit          fault;
    logic [15:0] rd;
    logic [31:0] ret;
    int          sp;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports completion or a fault.
  always @(posedge i_clk) begin
    #2;
    chk("rd_wr_exclusive", 32'(o_mem_read & o_mem_write), 32'(0));
    if (o_done || o_stack_fault) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'({o_done, o_stack_fault}), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("out_fault", 32'(o_stack_fault), 32'(mon_e.fault));
        chk("out_done", 32'(o_done), 32'(!mon_e.fault));
        chk("out_sp", 32'(o_sp), 32'(mon_e.sp));
        if (!mon_e.fault) begin
          chk("out_read_data", 32'(o_read_data), 32'(mon_e.rd));
          chk("out_ret_pc", o_ret_pc, mon_e.ret);
        end
      end
    end
  end

  task automatic check_access(input string tag, input bit rd, input bit wr,
                              input logic [15:0] ad, input logic [15:0] wd, input bit stall);
    chk({tag, "_mem_read"}, 32'(o_mem_read), 32'(rd));
    chk({tag, "_mem_write"}, 32'(o_mem_write), 32'(wr));
    if (rd || wr) chk({tag, "_mem_addr"}, 32'(o_mem_address), 32'(ad));
    if (wr) chk({tag, "_mem_wdata"}, 32'(o_mem_write_data), 32'(wd));
    chk({tag, "_stall"}, 32'(o_stall), 32'(stall));
  endtask

  // Entered and left at posedge+1; applies one operation and checks each access cycle.
  task automatic do_op(input bit v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] wd, input logic [31:0] pc);
    bit two = 0, flt = 0, done = 0;
    bit r1 = 0, w1 = 0, r2 = 0, w2 = 0;
    logic [15:0] ad1 = '0, ad2 = '0, wd1 = '0, wd2 = '0;
    if (v) begin
      case (op)
        OP_LOAD:  begin r1 = 1; ad1 = a; m_read = ref_rd(int'(a)); done = 1; end
        OP_STORE: begin w1 = 1; ad1 = a; wd1 = wd; ref_mem[int'(a)] = wd; done = 1; end
        OP_PUSH: begin
          if (m_sp < LIM) flt = 1;
          else begin
            w1 = 1; ad1 = 16'(m_sp); wd1 = wd; ref_mem[m_sp] = wd; m_sp = m_sp - 1; done = 1;
          end
        end
        OP_POP: begin
          if (m_sp > TOP - 1) flt = 1;
          else begin
            r1 = 1; ad1 = 16'(m_sp + 1); m_read = ref_rd(m_sp + 1); m_sp = m_sp + 1; done = 1;
          end
        end
        OP_CALL: begin
          if (m_sp < LIM + 1) flt = 1;
          else begin
            two = 1; done = 1;
            w1 = 1; ad1 = 16'(m_sp);     wd1 = pc[31:16];
            w2 = 1; ad2 = 16'(m_sp - 1); wd2 = pc[15:0];
            ref_mem[m_sp] = pc[31:16];
            ref_mem[m_sp - 1] = pc[15:0];
            m_sp = m_sp - 2;
          end
        end
        OP_RET: begin
          if (m_sp > TOP - 2) flt = 1;
          else begin
            two = 1; done = 1;
            r1 = 1; ad1 = 16'(m_sp + 1);
            r2 = 1; ad2 = 16'(m_sp + 2);
            m_ret = {ref_rd(m_sp + 2), ref_rd(m_sp + 1)};
            m_sp = m_sp + 2;
          end
        end
        default: ;
      endcase
    end
    if (flt) sb.push_back('{fault: 1'b1, rd: 16'h0, ret: 32'h0, sp: m_sp});
    else if (done) sb.push_back('{fault: 1'b0, rd: m_read, ret: m_ret, sp: m_sp});
    i_valid = v; i_op = op; i_address = a; i_write_data = wd; i_pc = pc;
    #2;
    check_access("access1", r1, w1, ad1, wd1, two);
    @(posedge i_clk); #1;
    if (two) begin
      // The second word must not depend on op/valid during SECOND.
      i_valid = 1'($urandom_range(0, 1));
      i_op = 3'($urandom_range(0, 7));
      #2;
      check_access("access2", r2, w2, ad2, wd2, 1'b0);
      @(posedge i_clk); #1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_op(1'b0, OP_NOP, 16'h0, 16'h0, 32'h0);
  endtask

  task automatic model_reset();
    m_sp = TOP; m_read = 16'h0; m_ret = 32'h0;
  endtask

  initial begin
    model_reset();
    i_reset = 1'b1; i_valid = 1'b1; i_op = OP_STORE;
    i_address = 16'h0010; i_write_data = 16'hFFFF; i_pc = 32'h0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    #2;
    chk("reset_mem_write", 32'(o_mem_write), 32'(0));
    chk("reset_mem_read", 32'(o_mem_read), 32'(0));
    chk("reset_sp", 32'(o_sp), 32'h0FFF);
    chk("reset_done", 32'(o_done), 32'(0));
    chk("reset_fault", 32'(o_stack_fault), 32'(0));
    chk("reset_stall", 32'(o_stall), 32'(0));
    chk("reset_read_data", 32'(o_read_data), 32'(0));
    chk("reset_ret_pc", o_ret_pc, 32'h0);
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    do_op(1, OP_POP, 16'h0, 16'h0, 32'h0);
    do_op(1, OP_PUSH, 16'h0, 16'hABCD, 32'h0);
    chk("mem_fff_push", 32'(mem[16'h0FFF]), 32'h0000ABCD);
    do_op(1, OP_POP, 16'h0, 16'h0, 32'h0);
    do_op(1, OP_CALL, 16'h0, 16'h0, 32'h1234_5678);
    chk("mem_fff_call", 32'(mem[16'h0FFF]), 32'h00001234);
    chk("mem_ffe_call", 32'(mem[16'h0FFE]), 32'h00005678);
    do_op(1, OP_RET, 16'h0, 16'h0, 32'h0);
    do_op(1, OP_STORE, 16'h0010, 16'h00A5, 32'h0);
    do_op(1, OP_LOAD, 16'h0010, 16'h0, 32'h0);
    do_op(1, OP_PUSH, 16'h0, 16'h1111, 32'h0);
    do_op(1, OP_RET, 16'h0, 16'h0, 32'h0);
    do_op(1, OP_POP, 16'h0, 16'h0, 32'h0);
    idle(2);

    for (int i = 0; i < 2047; i++) do_op(1, OP_PUSH, 16'h0, 16'(i), 32'h0);
    chk("sp_at_limit", 32'(o_sp), 32'h0800);
    do_op(1, OP_PUSH, 16'h0, 16'hBEEF, 32'h0);
    do_op(1, OP_PUSH, 16'h0, 16'hDEAD, 32'h0);
    chk("no_write_below_limit", 32'(mem[16'h07FF]), 32'(ref_rd(16'h07FF)));
    do_op(1, OP_CALL, 16'h0, 16'h0, 32'hAAAA_5555);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      do_op(1'($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom), $urandom);
    end
    idle(3);

    // Reset landing in the second CALL cycle.
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    model_reset();
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_op = OP_CALL; i_pc = 32'hCAFE_F00D;
    #2;
    chk("rstcall_stall", 32'(o_stall), 32'(1));
    chk("rstcall_write1", 32'(o_mem_write), 32'(1));
    ref_mem[TOP] = 16'hCAFE;
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    #2;
    chk("rstcall_write2", 32'(o_mem_write), 32'(0));
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_valid = 1'b0;
    #2;
    chk("rstcall_sp", 32'(o_sp), 32'h0FFF);
    chk("rstcall_stall_after", 32'(o_stall), 32'(0));
    chk("rstcall_done", 32'(o_done), 32'(0));
    chk("rstcall_mem_ffe", 32'(mem[16'h0FFE]), 32'(ref_rd(TOP - 1)));
    @(posedge i_clk); #1;
    do_op(1, OP_PUSH, 16'h0, 16'h5555, 32'h0);
    do_op(1, OP_POP, 16'h0, 16'h0, 32'h0);
    idle(3);

    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
